ir_packet_encoder: RTL and testbench
====================================

# ir_packet_encoder

Packet-level IR encoder for one car colour: on each send request it captures a 4-bit drive command and emits one complete modulated IR packet on `IR_LED`. The packet is a start burst, then a car-select burst, then one burst per command bit, with a gap after each burst. It sits directly downstream of the bus-mapped IR peripheral. That peripheral supplies the `COMMAND` nibble and the periodic `SEND_PACKET` strobe, and consumes `IR_LED`. The peripheral instantiates one encoder per car colour, each with its own timing parameters.

## Interface
- `HCYC_PULSE`, default 1388: carrier half-period in clocks, minus 1. Carrier period is 2·(HCYC_PULSE+1) clocks.
- `SZ_START`, default 190: start burst length in carrier periods, minus 1.
- `SZ_CARSEL`, default 46: car-select burst length in carrier periods, minus 1.
- `SZ_GAP`, default 24: gap length in carrier periods, minus 1.
- `SZ_ASSERT`, default 46: burst length for a command bit = 1, in carrier periods, minus 1.
- `SZ_DEASSERT`, default 21: burst length for a command bit = 0, in carrier periods, minus 1.
- `CLK` in 1: system clock, 100 MHz.
- `RESET` in 1: synchronous, active-high reset.
- `COMMAND` in 4: bit 0 = right, 1 = left, 2 = backward, 3 = forward.
- `SEND_PACKET` in 1: single-cycle request to start a packet.
- `IR_LED` out 1: modulated IR output. Registered; reset value 0.
- `BUSY` out 1: high while a packet is in progress. Registered; reset value 0.
- `PKT_DONE` out 1: one-cycle pulse when a packet completes. Registered; reset value 0.

## Operation
- State sequence: IDLE → START → GAP0 → CARSEL → GAP1 → RIGHT → GAP2 → LEFT → GAP3 → BACK → GAP4 → FWD → GAP5 → IDLE.
- Segment lengths, in carrier periods:
  - START = SZ_START+1.
  - CARSEL = SZ_CARSEL+1.
  - Every GAPn = SZ_GAP+1.
  - RIGHT/LEFT/BACK/FWD = SZ_ASSERT+1 if the captured bit is 1, otherwise SZ_DEASSERT+1.
- Burst segments (START, CARSEL, bit states): `IR_LED` follows the carrier phase. It is high for HCYC_PULSE+1 clocks, then low for HCYC_PULSE+1 clocks, and repeats.
- GAP segments and IDLE: `IR_LED` = 0.
- Accepting a request:
  - `SEND_PACKET` sampled high in IDLE captures `COMMAND` into an internal register.
  - Changes on `COMMAND` after capture do not affect the packet in progress.
- Carrier counting:
  - The half-period counter (16 bit) and the period counter (8 bit) restart at every segment boundary.
  - The carrier phase restarts high at every segment boundary, so every segment contains only whole carrier periods.
- Segment advance: on the clock that ends the low half of the last period of a segment.
- `SEND_PACKET` outside IDLE is ignored. It is neither queued nor allowed to restart the packet.
- `RESET` mid-packet: the next edge forces IDLE, `IR_LED` = 0, `BUSY` = 0, `PKT_DONE` = 0, and clears all counters and the captured command.

## Timing
- Let edge k be the edge that samples `SEND_PACKET` = 1 in IDLE.
- From cycle k+1:
  - `BUSY` = 1.
  - `IR_LED` = 1 for the first HCYC_PULSE+1 cycles of START.
- Total packet length L, in clocks = 2·(HCYC_PULSE+1) · Σ(segment periods).
- `BUSY` is high for cycles k+1 … k+L.
- At edge k+L:
  - State returns to IDLE.
  - `BUSY` drops.
  - `PKT_DONE` = 1 for exactly cycle k+L+1.
- Back-to-back packets: a `SEND_PACKET` sampled at edge k+L+1 (while `PKT_DONE` is high) is accepted. Minimum request spacing is L+1 cycles.
- Simultaneous `RESET` and `SEND_PACKET`: `RESET` wins and no packet starts.

## Test plan
All scenarios use small parameters: HCYC_PULSE=1 (4-clock carrier), SZ_START=2, SZ_CARSEL=1, SZ_GAP=0, SZ_ASSERT=1, SZ_DEASSERT=0.
- **All-zero command:** `COMMAND`=0000, one `SEND_PACKET` pulse.
  - `BUSY` high exactly 60 cycles, then a `PKT_DONE` pulse.
  - `IR_LED` pattern: 12 clocks carrier (1100 ×3), 4 low, 8 carrier, 4 low, then (4 carrier, 4 low) ×4.
- **All-ones command:** `COMMAND`=1111.
  - `BUSY` is 76 cycles.
  - Each bit burst is 8 clocks of carrier (1100 1100).
- **Mixed command:** `COMMAND`=1010.
  - Bit bursts, in order RIGHT/LEFT/BACK/FWD: 4, 8, 4, 8 clocks.
  - `BUSY` is 68 cycles.
- **Capture and ignored requests:** change `COMMAND` and pulse `SEND_PACKET` mid-packet.
  - The waveform matches the originally captured command.
  - No extra packet is produced.
  - `PKT_DONE` fires once.
- **Reset mid-burst:** assert `RESET` during CARSEL.
  - `IR_LED`, `BUSY` and `PKT_DONE` are 0 on the next cycle.
  - A subsequent request produces a full, correct 60-cycle packet for `COMMAND`=0000.
- **Back-to-back and default-parameter checks:**
  - Pulse `SEND_PACKET` on the `PKT_DONE` cycle: the second packet starts the next cycle with no idle gap beyond one cycle.
  - With default parameters, measure the carrier period: 2778 clocks.

Source files
------------

// File: rtl/ir_packet_encoder.sv
// ir_packet_encoder
// Turns one send request into a complete modulated IR packet for a single car
// colour: start burst, car-select burst, then one burst per command bit
// (right, left, backward, forward), each burst followed by a carrier-less gap.
// The carrier phase and both counters restart at every segment boundary, so
// each segment holds whole carrier periods only.
module ir_packet_encoder #(
    parameter int HCYC_PULSE  = 1388,
    parameter int SZ_START    = 190,
    parameter int SZ_CARSEL   = 46,
    parameter int SZ_GAP      = 24,
    parameter int SZ_ASSERT   = 46,
    parameter int SZ_DEASSERT = 21
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COMMAND,
    input  logic       SEND_PACKET,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PKT_DONE
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_GAP0   = 4'd2;
    localparam logic [3:0] S_CARSEL = 4'd3;
    localparam logic [3:0] S_GAP1   = 4'd4;
    localparam logic [3:0] S_RIGHT  = 4'd5;
    localparam logic [3:0] S_GAP2   = 4'd6;
    localparam logic [3:0] S_LEFT   = 4'd7;
    localparam logic [3:0] S_GAP3   = 4'd8;
    localparam logic [3:0] S_BACK   = 4'd9;
    localparam logic [3:0] S_GAP4   = 4'd10;
    localparam logic [3:0] S_FWD    = 4'd11;
    localparam logic [3:0] S_GAP5   = 4'd12;

    localparam logic [15:0] HC_MAX     = 16'(HCYC_PULSE);
    localparam logic [7:0]  N_START    = 8'(SZ_START);
    localparam logic [7:0]  N_CARSEL   = 8'(SZ_CARSEL);
    localparam logic [7:0]  N_GAP      = 8'(SZ_GAP);
    localparam logic [7:0]  N_ASSERT   = 8'(SZ_ASSERT);
    localparam logic [7:0]  N_DEASSERT = 8'(SZ_DEASSERT);

    logic [3:0]  r_state;
    logic [3:0]  r_cmd;
    logic [15:0] r_hcnt;
    logic [7:0]  r_pcnt;
    logic        r_phase_hi;
    logic        r_led;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_seg_max;
    logic        w_half_end;
    logic        w_seg_end;
    logic        w_start;
    logic        w_adv;
    logic [3:0]  w_next_state;
    logic [15:0] w_next_hcnt;
    logic [7:0]  w_next_pcnt;
    logic        w_next_phase;

    // Burst states carry the carrier; gaps and idle keep the LED dark.
    function automatic logic is_burst(input logic [3:0] s);
        case (s)
            S_START, S_CARSEL, S_RIGHT, S_LEFT, S_BACK, S_FWD: is_burst = 1'b1;
            default:                                           is_burst = 1'b0;
        endcase
    endfunction

    assign IR_LED   = r_led;
    assign BUSY     = r_busy;
    assign PKT_DONE = r_done;

    // Last period index of the current segment; bit bursts depend on the captured command.
    always_comb begin
        w_seg_max = N_GAP;
        case (r_state)
            S_START:  w_seg_max = N_START;
            S_CARSEL: w_seg_max = N_CARSEL;
            S_RIGHT:  w_seg_max = r_cmd[0] ? N_ASSERT : N_DEASSERT;
            S_LEFT:   w_seg_max = r_cmd[1] ? N_ASSERT : N_DEASSERT;
            S_BACK:   w_seg_max = r_cmd[2] ? N_ASSERT : N_DEASSERT;
            S_FWD:    w_seg_max = r_cmd[3] ? N_ASSERT : N_DEASSERT;
            default:  w_seg_max = N_GAP;
        endcase
    end

    assign w_half_end = (r_hcnt == HC_MAX);
    assign w_seg_end  = w_half_end && !r_phase_hi && (r_pcnt == w_seg_max);
    assign w_start    = (r_state == S_IDLE) && SEND_PACKET;
    assign w_adv      = w_start || ((r_state != S_IDLE) && w_seg_end);

    // Next state and carrier counters; a segment boundary restarts the phase high.
    always_comb begin
        w_next_state = r_state;
        w_next_hcnt  = r_hcnt;
        w_next_pcnt  = r_pcnt;
        w_next_phase = r_phase_hi;
        if (w_adv) begin
            if (w_start)
                w_next_state = S_START;
            else if (r_state == S_GAP5)
                w_next_state = S_IDLE;
            else
                w_next_state = r_state + 4'd1;
            w_next_hcnt  = 16'd0;
            w_next_pcnt  = 8'd0;
            w_next_phase = 1'b1;
        end else if (r_state != S_IDLE) begin
            if (w_half_end) begin
                w_next_hcnt  = 16'd0;
                w_next_phase = ~r_phase_hi;
                if (!r_phase_hi)
                    w_next_pcnt = r_pcnt + 8'd1;
            end else begin
                w_next_hcnt = r_hcnt + 16'd1;
            end
        end
    end

    // State, counters, captured command and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cmd      <= 4'd0;
            r_hcnt     <= 16'd0;
            r_pcnt     <= 8'd0;
            r_phase_hi <= 1'b0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_hcnt     <= w_next_hcnt;
            r_pcnt     <= w_next_pcnt;
            r_phase_hi <= w_next_phase;
            if (w_start)
                r_cmd <= COMMAND;
            r_led      <= is_burst(w_next_state) && w_next_phase;
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (r_state == S_GAP5) && w_seg_end;
        end
    end

endmodule

// File: tb/tb_ir_packet_encoder.sv
// Testbench for ir_packet_encoder: small-parameter instance checked every cycle
// against a waveform-queue model, plus a default-parameter instance for the
// carrier period.
module tb_ir_packet_encoder;

    localparam int HC  = 1;
    localparam int SS  = 2;
    localparam int SC  = 1;
    localparam int SG  = 0;
    localparam int SA  = 1;
    localparam int SD  = 0;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       send = 1'b0;
    logic       led, busy, done;

    logic       d_rst = 1'b1;
    logic       d_send = 1'b0;
    logic       d_led, d_busy, d_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Model: the remaining LED samples of the packet in flight, one per clock.
    bit q[$];
    bit m_done = 1'b0;

    always #5 CLK = ~CLK;

    ir_packet_encoder #(
        .HCYC_PULSE(HC), .SZ_START(SS), .SZ_CARSEL(SC),
        .SZ_GAP(SG), .SZ_ASSERT(SA), .SZ_DEASSERT(SD)
    ) u_dut (
        .CLK(CLK), .RESET(rst), .COMMAND(cmd), .SEND_PACKET(send),
        .IR_LED(led), .BUSY(busy), .PKT_DONE(done)
    );

    ir_packet_encoder u_def (
        .CLK(CLK), .RESET(d_rst), .COMMAND(cmd), .SEND_PACKET(d_send),
        .IR_LED(d_led), .BUSY(d_busy), .PKT_DONE(d_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wave(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void build(input logic [3:0] c);
        int per [13];
        per[0] = SS + 1;  per[1] = SG + 1; per[2] = SC + 1; per[3] = SG + 1;
        for (int b = 0; b < 4; b++) begin
            per[4 + 2*b] = c[b] ? SA + 1 : SD + 1;
            per[5 + 2*b] = SG + 1;
        end
        for (int s = 0; s < 13; s++)
            for (int p = 0; p < per[s]; p++) begin
                for (int h = 0; h <= HC; h++) q.push_back((s % 2) == 0);
                for (int h = 0; h <= HC; h++) q.push_back(1'b0);
            end
    endfunction

    // Model advance on each clock edge.
    always @(posedge CLK) begin
        if (rst) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            m_done = (q.size() == 1);
            if (q.size() != 0)
                void'(q.pop_front());
            else if (send)
                build(cmd);
        end
    end

    // Every-cycle comparison against the model, plus PKT_DONE pulse counting.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("led", int'(led), (q.size() != 0) ? int'(q[0]) : 0);
            check("busy", int'(busy), int'(q.size() != 0));
            check("pkt_done", int'(done), int'(m_done));
        end
        if (done) done_cnt++;
    end

    task automatic issue(input logic [3:0] c);
        cmd  = c;
        send = 1'b1;
        @(negedge CLK);
        send = 1'b0;
    endtask

    // Called on cycle k+1; returns on cycle k+L+1 (the PKT_DONE cycle).
    task automatic measure(input string name, input logic [3:0] c, input int exp_len,
                           input logic [95:0] exp_wave, input bit disturb);
        logic [95:0] cap = '0;
        int n = 0;
        while (busy && n < 300) begin
            cap = {cap[94:0], led};
            n++;
            if (disturb) begin
                if (n == 20) begin cmd = ~c; send = 1'b1; end
                if (n == 21) send = 1'b0;
                if (n == 50) begin cmd = 4'd0; send = 1'b1; end
                if (n == 51) send = 1'b0;
            end
            @(negedge CLK);
        end
        check({name, "_busy_len"}, n, exp_len);
        check_wave({name, "_wave"}, cap, exp_wave);
        check({name, "_done_pulse"}, int'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int pre;
        int hi;
        int lo;
        repeat (3) @(negedge CLK);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        d_rst = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);

        // Model pins: packet lengths straight from the segment sums.
        build(4'b0000); check("model_len_0000", q.size(), 60); q.delete();
        build(4'b1111); check("model_len_1111", q.size(), 76); q.delete();

        issue(4'b0000); measure("zero", 4'b0000, 60, 96'hCCC0CC0C0C0C0C0, 1'b0);
        issue(4'b1111); measure("ones", 4'b1111, 76, 96'hCCC0CC0CC0CC0CC0CC0, 1'b0);
        issue(4'b1010); measure("mixed", 4'b1010, 68, 96'hCCC0CC0C0CC0C0CC0, 1'b0);

        // Capture: command changes and extra requests mid-packet are ignored.
        repeat (2) @(negedge CLK);
        pre = done_cnt;
        issue(4'b1010); measure("capture", 4'b1010, 68, 96'hCCC0CC0C0CC0C0CC0, 1'b1);
        repeat (5) @(negedge CLK);
        check("capture_done_once", done_cnt - pre, 1);
        check("capture_no_extra", int'(busy), 0);

        // Reset during CARSEL.
        cmd = 4'b0000;
        issue(4'b0000);
        repeat (18) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check("rst_mid_led", int'(led), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        @(negedge CLK);
        issue(4'b0000); measure("after_rst", 4'b0000, 60, 96'hCCC0CC0C0C0C0C0, 1'b0);

        // Simultaneous reset and request: no packet.
        @(negedge CLK);
        rst = 1'b1; send = 1'b1;
        @(negedge CLK);
        rst = 1'b0; send = 1'b0;
        check("rst_wins_busy", int'(busy), 0);
        @(negedge CLK);
        check("rst_wins_busy2", int'(busy), 0);

        // Back-to-back: second request on the PKT_DONE cycle.
        issue(4'b0000); measure("b2b_first", 4'b0000, 60, 96'hCCC0CC0C0C0C0C0, 1'b0);
        issue(4'b1111);
        check("b2b_start_busy", int'(busy), 1);
        measure("b2b_second", 4'b1111, 76, 96'hCCC0CC0CC0CC0CC0CC0, 1'b0);

        // Randomized traffic against the model.
        pre = done_cnt;
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            send = ($urandom_range(0, 15) == 0);
            cmd  = 4'($urandom_range(0, 15));
            @(negedge CLK);
        end
        rst = 1'b0; send = 1'b0;
        repeat (100) @(negedge CLK);
        n_tests++;
        if (done_cnt - pre < 10) begin
            n_fail++;
            $display("FAIL random_activity: got %0d packets, expected at least 10", done_cnt - pre);
        end

        // Default parameters: carrier period measured on the first START period.
        d_send = 1'b1;
        @(negedge CLK);
        d_send = 1'b0;
        check("def_busy", int'(d_busy), 1);
        hi = 0;
        while (d_led && hi < 5000) begin hi++; @(negedge CLK); end
        lo = 0;
        while (!d_led && lo < 5000) begin lo++; @(negedge CLK); end
        check("def_half_period", hi, 1389);
        check("def_period", hi + lo, 2778);
        check("def_no_done", int'(d_done), 0);
        d_rst = 1'b1;
        @(negedge CLK);
        check("def_reset_led", int'(d_led), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
